// File: rtl/alu_mc_if.sv
// Request/response bundle of the multi-cycle ALU.
// The master drives the request; the slave returns the result, flags and status.
interface alu_mc_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  start;
  logic [3:0]            sel;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic [DATA_WIDTH-1:0] z;
  logic [3:0]            flag;
  logic                  busy;
  logic                  done;

  modport master (
    output start, sel, a, b,
    input  z, flag, busy, done
  );

  modport slave (
    input  start, sel, a, b,
    output z, flag, busy, done
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops and a serial shift-add multiply.
// flag = {V, N, Z, C}; results are registered and marked by a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start; operands are latched on acceptance
// EXEC  | single-cycle op; result written on the exit edge
// MUL   | shift-add multiply, one multiplier bit per cycle
module alu_mc #(
  parameter int DATA_WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_mc_if.slave  bus
);
  localparam int W  = DATA_WIDTH;
  localparam int M  = W - 1;
  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;

  state_t          state, state_nxt;
  logic [3:0]      op_sel;
  logic [W-1:0]    op_a, op_b;
  logic            op_cin;
  logic [2*W-1:0]  prod, prod_nxt;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    z_q;
  logic [3:0]      flag_q;
  logic            done_q;

  logic            accept, mul_last;
  logic            busy, ld, step, wr_exec, wr_mul;

  logic [W:0]      sum, mul_add;
  logic [W-1:0]    alu_z, mul_z;
  logic            alu_c, alu_v, alu_valid;
  logic [3:0]      alu_flag, mul_flag;

  // A start seen alongside done is dropped, so a back-to-back request waits one cycle.
  assign accept   = (state == IDLE) && bus.start && !done_q;
  assign mul_last = (state == MUL) && (cnt == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (bus.sel == 4'b1000) ? MUL : EXEC;
      EXEC: state_nxt = IDLE;
      MUL:  if (mul_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    ld      = accept;
    step    = (state == MUL);
    wr_exec = (state == EXEC);
    wr_mul  = mul_last;
  end

  always_comb begin
    sum       = '0;
    alu_z     = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    alu_valid = 1'b1;
    case (op_sel)
      4'b0001: begin
        sum   = {1'b0, op_a} + {1'b0, op_b};
        alu_z = sum[W-1:0];
        alu_c = sum[W];
        alu_v = (op_a[M] == op_b[M]) && (alu_z[M] != op_a[M]);
      end
      4'b0010: begin
        sum   = {1'b0, op_a} + {1'b0, ~op_b} + (W+1)'(1);
        alu_z = sum[W-1:0];
        alu_c = sum[W];
        alu_v = (op_a[M] != op_b[M]) && (alu_z[M] != op_a[M]);
      end
      4'b1001: begin
        sum   = {1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, op_cin};
        alu_z = sum[W-1:0];
        alu_c = sum[W];
        alu_v = (op_a[M] == op_b[M]) && (alu_z[M] != op_a[M]);
      end
      4'b0011: alu_z = op_a & op_b;
      4'b0100: alu_z = op_a | op_b;
      4'b0101: alu_z = op_a ^ op_b;
      4'b0110: begin
        alu_z = {op_a[W-2:0], 1'b0};
        alu_c = op_a[M];
      end
      4'b0111: begin
        alu_z = {1'b0, op_a[W-1:1]};
        alu_c = op_a[0];
      end
      default: alu_valid = 1'b0;
    endcase
    alu_flag = alu_valid ? {alu_v, alu_z[M], (alu_z == '0), alu_c} : 4'b0000;
  end

  // Upper half accumulates the partial product while the multiplier shifts out of the lower half.
  always_comb begin
    mul_add  = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, op_a} : '0);
    prod_nxt = {mul_add, prod[W-1:1]};
    mul_z    = prod_nxt[W-1:0];
    mul_flag = {1'b0, mul_z[M], (mul_z == '0), |prod_nxt[2*W-1:W]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_sel <= '0;
      op_a   <= '0;
      op_b   <= '0;
      op_cin <= 1'b0;
      prod   <= '0;
      cnt    <= '0;
      z_q    <= '0;
      flag_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (ld) begin
        op_sel <= bus.sel;
        op_a   <= bus.a;
        op_b   <= bus.b;
        op_cin <= flag_q[0];
        prod   <= {{W{1'b0}}, bus.b};
        cnt    <= CW'(W);
      end
      if (step) begin
        prod <= prod_nxt;
        cnt  <= cnt - CW'(1);
      end
      if (wr_exec) begin
        z_q    <= alu_z;
        flag_q <= alu_flag;
        done_q <= 1'b1;
      end
      if (wr_mul) begin
        z_q    <= mul_z;
        flag_q <= mul_flag;
        done_q <= 1'b1;
      end
    end
  end

  assign bus.z    = z_q;
  assign bus.flag = flag_q;
  assign bus.busy = busy;
  assign bus.done = done_q;
endmodule

// File: tb/tb_alu_mc.sv
// Randomized self-checking bench for alu_mc (DATA_WIDTH=8) against an arithmetic reference model.
module tb_alu_mc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_mc_if #(.DATA_WIDTH(8)) bus();
  alu_mc #(.DATA_WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int   n_vec = 0;
  int   n_err = 0;
  logic m_c   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Returns {V, N, Z, C, z[7:0]} computed from plain integer arithmetic.
  function automatic logic [11:0] ref_op(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic cin);
    int ua, ub, sa, sb, r, sr;
    logic c, v;
    logic [7:0] zz;
    ua = int'(a); ub = int'(b);
    sa = $signed(a); sb = $signed(b);
    r = 0; sr = 0; c = 1'b0; v = 1'b0;
    case (op)
      4'd1: begin r = ua + ub;            sr = sa + sb;       c = r > 255; v = sr > 127 || sr < -128; end
      4'd2: begin r = ua + (255 - ub) + 1; sr = sa - sb;      c = r > 255; v = sr > 127 || sr < -128; end
      4'd9: begin r = ua + ub + int'(cin); sr = sa + sb + int'(cin); c = r > 255; v = sr > 127 || sr < -128; end
      4'd3: r = ua & ub;
      4'd4: r = ua | ub;
      4'd5: r = ua ^ ub;
      4'd6: begin r = ua * 2; c = ua >= 128; end
      4'd7: begin r = ua / 2; c = (ua % 2) == 1; end
      4'd8: begin r = ua * ub; c = r > 255; end
      default: return 12'h000;
    endcase
    zz = 8'(r % 256);
    return {v, zz[7], zz == 8'h00, c, zz};
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input int poke);
    logic [11:0] exp;
    int lat, cyc;
    logic seen;
    exp = ref_op(op, a, b, m_c);
    lat = (op == 4'd8) ? 8 : 1;
    bus.start = 1'b1; bus.sel = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.sel = 4'($urandom); bus.a = 8'($urandom); bus.b = 8'($urandom);
    check("busy_after_accept", 32'(bus.busy), 32'd1);
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 20) begin
      if (poke != 0 && cyc == poke) begin
        bus.start = 1'b1; bus.sel = 4'd1; bus.a = 8'h01; bus.b = 8'h01;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      cyc++;
      if (bus.done) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 32'd1);
    check("latency", 32'(cyc), 32'(lat));
    check("z", 32'(bus.z), 32'(exp[7:0]));
    check("flag", 32'(bus.flag), 32'(exp[11:8]));
    check("busy_at_done", 32'(bus.busy), 32'd0);
    m_c = exp[8];
    // A request raised in the done cycle must be dropped.
    bus.start = 1'b1; bus.sel = 4'd1; bus.a = 8'($urandom); bus.b = 8'($urandom);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("start_in_done_ignored", 32'(bus.busy), 32'd0);
    check("z_hold", 32'(bus.z), 32'(exp[7:0]));
    check("flag_hold", 32'(bus.flag), 32'(exp[11:8]));
  endtask

  initial begin
    bus.start = 1'b0; bus.sel = 4'd0; bus.a = 8'h00; bus.b = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_z", 32'(bus.z), 32'h0);
    check("rst_flag", 32'(bus.flag), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(4'd1, 8'hFF, 8'h01, 0);
    run_op(4'd9, 8'h00, 8'h00, 0);
    run_op(4'd2, 8'h05, 8'h07, 0);
    run_op(4'd2, 8'h80, 8'h01, 0);
    run_op(4'd8, 8'h0F, 8'h11, 0);
    run_op(4'd8, 8'h10, 8'h10, 0);
    run_op(4'd8, 8'hF3, 8'hC7, 3);
    run_op(4'd15, 8'hAA, 8'h55, 0);
    run_op(4'd0, 8'h12, 8'h34, 0);
    run_op(4'd2, 8'h05, 8'h07, 0);

    // Reset three cycles into a multiply: outputs clear at once, no done.
    bus.start = 1'b1; bus.sel = 4'd8; bus.a = 8'h0F; bus.b = 8'h11;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_z", 32'(bus.z), 32'h0);
    check("midrst_flag", 32'(bus.flag), 32'h0);
    check("midrst_busy", 32'(bus.busy), 32'h0);
    check("midrst_done", 32'(bus.done), 32'h0);
    repeat (2) @(posedge clk);
    #1 check("inrst_done", 32'(bus.done), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    m_c = 1'b0;
    @(posedge clk); #1;
    check("postrst_done", 32'(bus.done), 32'h0);
    run_op(4'd3, 8'hF0, 8'h3C, 0);

    for (int i = 0; i < 150; i++) begin
      run_op(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
             ($urandom_range(0, 3) == 0) ? 2 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter DATA_WIDTH, default 8, is the operand and result width; legal values are 4 to 32.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 Port start, input, 1 bit: request strobe, sampled on rising clk.
REQ-005 Port sel, input, 4 bits: opcode, sampled with start.
REQ-006 Port a, input, DATA_WIDTH bits: operand A, sampled with start.
REQ-007 Port b, input, DATA_WIDTH bits: operand B, sampled with start.
REQ-008 Port z, output, DATA_WIDTH bits: registered result.
REQ-009 Port flag, output, 4 bits: registered flags, bit0 C (carry), bit1 Z (zero), bit2 N (negative), bit3 V (overflow).
REQ-010 Port busy, output, 1 bit: high while an operation is in flight.
REQ-011 Port done, output, 1 bit: one-cycle pulse marking the cycle in which z and flag are updated.

Function
REQ-012 The FSM SHALL have three states, IDLE, EXEC and MUL, and SHALL leave reset in IDLE.
REQ-013 In IDLE, start=1 at edge k SHALL latch sel, a and b into internal registers; the next state is MUL if sel=1000, otherwise EXEC.
REQ-014 busy SHALL be 1 in EXEC and MUL and 0 in IDLE; start SHALL be ignored while busy=1.
REQ-015 EXEC latency: z and flag SHALL be written at edge k+1, with done=1 for that one cycle and a return to IDLE.
REQ-016 MUL latency: the unit SHALL perform an unsigned shift-add multiply, one multiplier bit per cycle, counted by a log2(DATA_WIDTH)+1-bit counter.
REQ-017 MUL results SHALL be written at edge k+DATA_WIDTH, with done=1 for that one cycle and a return to IDLE.
REQ-018 z and flag SHALL hold their values between operations; done SHALL be 0 in every other cycle.
REQ-019 Opcode 0001 ADD: z = a + b, C = carry out.
REQ-020 Opcode 0010 SUB: z = a + ~b + 1, C = carry out (1 means no borrow, i.e. a >= b unsigned).
REQ-021 Opcodes 0011 AND, 0100 OR and 0101 XOR: z = bitwise result, with C=0 and V=0.
REQ-022 Opcode 0110 SHL: z = a << 1, C = a[MSB], V = 0.
REQ-023 Opcode 0111 SHR (logical): z = a >> 1, C = a[0], V = 0.
REQ-024 Opcode 1000 MUL: z = low DATA_WIDTH bits of a*b, C = 1 if the high half is nonzero, V = 0.
REQ-025 Opcode 1001 ADC: z = a + b + flag[0] as it stood when the op was accepted, C = carry out.
REQ-026 ADD, SUB and ADC SHALL set V to signed two's-complement overflow.
REQ-027 Every opcode SHALL set Z = (z == 0) and N = z[MSB].
REQ-028 Opcode 0000 and any undefined opcode SHALL take the EXEC path and write z=0 and flag=0000, with done pulsed.
REQ-029 A start asserted in the same cycle as done SHALL be ignored; the earliest acceptance is the first IDLE cycle after done.
REQ-030 Arithmetic SHALL use DATA_WIDTH+1-bit internal sums; there is no other width extension.

Reset
REQ-031 While rst_n=0, the block SHALL immediately force: state IDLE, z=0, flag=0000, busy=0, done=0, MUL counter and operand registers 0.
REQ-032 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first request after rst_n rises SHALL be accepted normally.

Verification (DATA_WIDTH=8)
REQ-033 ADD a=FF, b=01 -> z=00, flag C=1 Z=1 N=0 V=0; done exactly one cycle after acceptance; busy high for 1 cycle.
REQ-034 SUB a=05, b=07 -> z=FE, C=0 N=1 Z=0 V=0; SUB a=80, b=01 -> z=7F, C=1 V=1.
REQ-035 MUL a=0F, b=11 -> z=FF, C=0, done at edge k+8, busy high 8 cycles; MUL a=10, b=10 -> z=00, C=1, Z=1.
REQ-036 ADD FF+01 (C=1) followed by ADC a=00, b=00 -> z=01, C=0; start pulsed during a MUL -> ignored, and the MUL result is unchanged.
REQ-037 rst_n driven low 3 cycles into a MUL -> z=00, flag=0, busy=0 immediately with no done; after release, AND a=F0, b=3C -> z=30 in 1 cycle.
REQ-038 sel=1111 with a=AA -> z=00, flag=0000, done pulsed.
